// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per request over a req/ready
// handshake, with lane steering, load extension and error reporting.
module lsu #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              is_l_instr,
    input  logic              is_s_instr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] alu_mem_addr,
    input  logic [1:0]        byte_off,
    input  logic [31:0]       alu_result,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       load_data,
    output logic              rd_wr_en
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    function automatic logic access_ok(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] off);
        logic legal;
        logic misaligned;
        case (f3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = is_load;
            default:                legal = 1'b0;
        endcase
        misaligned = ((f3[1:0] == 2'b01) && (off == 2'b11)) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return legal && !misaligned;
    endfunction

    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] word,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  r = {{24{sh[7]}}, sh[7:0]};
            3'b001:  r = {{16{sh[15]}}, sh[15:0]};
            3'b100:  r = {24'h000000, sh[7:0]};
            3'b101:  r = {16'h0000, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic              is_load_r, is_load_s;
    logic [2:0]        funct3_r, funct3_s;
    logic [1:0]        off_r, off_s;
    logic              req_s, we_s, done_s, err_s, rd_wr_en_s, busy_s;
    logic [ADDR_W-1:0] addr_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, load_data_s;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        is_load_s   = is_load_r;
        funct3_s    = funct3_r;
        off_s       = off_r;
        req_s       = dmem_req;
        we_s        = dmem_we;
        addr_s      = dmem_addr;
        be_s        = dmem_be;
        wdata_s     = dmem_wdata;
        load_data_s = load_data;
        done_s      = 1'b0;
        err_s       = 1'b0;
        rd_wr_en_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_en) begin
                    if ((is_l_instr ^ is_s_instr) && access_ok(is_l_instr, funct3, byte_off)) begin
                        state_s   = REQ;
                        cnt_s     = '0;
                        is_load_s = is_l_instr;
                        funct3_s  = funct3;
                        off_s     = byte_off;
                        req_s     = 1'b1;
                        we_s      = is_s_instr;
                        addr_s    = alu_mem_addr;
                        be_s      = lane_be(funct3, byte_off);
                        wdata_s   = lane_wdata(funct3, alu_result);
                    end else begin
                        // Bad request shape or access: report at once, never touch memory.
                        state_s = DONE;
                        done_s  = 1'b1;
                        err_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_s = DONE;
                    req_s   = 1'b0;
                    done_s  = 1'b1;
                    if (is_load_r) begin
                        load_data_s = extend_load(funct3_r, dmem_rdata, off_r);
                        rd_wr_en_s  = 1'b1;
                    end else begin
                        load_data_s = load_data;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_s = DONE;
                    req_s   = 1'b0;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            is_load_r  <= 1'b0;
            funct3_r   <= 3'b000;
            off_r      <= 2'b00;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0000_0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_data  <= 32'h0000_0000;
            rd_wr_en   <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            is_load_r  <= is_load_s;
            funct3_r   <= funct3_s;
            off_r      <= off_s;
            dmem_req   <= req_s;
            dmem_we    <= we_s;
            dmem_addr  <= addr_s;
            dmem_be    <= be_s;
            dmem_wdata <= wdata_s;
            busy       <= busy_s;
            done       <= done_s;
            err        <= err_s;
            load_data  <= load_data_s;
            rd_wr_en   <= rd_wr_en_s;
        end
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the multicycle core, directly downstream of the ALU. It takes the word address and store data the ALU produces, plus the byte offset and access width from decode, and runs one data-memory transaction per request through a req/ready handshake. It returns aligned, sign- or zero-extended load data and a register write-enable to writeback. It flags misaligned, illegal and timed-out accesses.

## Interface
Parameters:
- ADDR_W, 12, word-address width (matches ALU mem address).
- TIMEOUT, 16, max REQ cycles waiting for dmem_ready before error; must be ≥1.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_en  in  1  start strobe from control; sampled only in IDLE.
- is_l_instr  in  1  load request.
- is_s_instr  in  1  store request.
- funct3  in  3  width: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- alu_mem_addr  in  ADDR_W  word address from ALU.
- byte_off  in  2  byte offset within word.
- alu_result  in  32  store data (rs2 value) from ALU.
- dmem_req  out  1  memory request, held until accepted.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word address.
- dmem_be  out  4  byte-lane enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  memory accept/response; dmem_rdata valid in the same cycle.
- dmem_rdata  in  32  read word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; misaligned, illegal or timeout.
- load_data  out  32  extended load result; held until next done.
- rd_wr_en  out  1  pulses with done for successful loads only.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: when mem_en=1 and exactly one of is_l_instr and is_s_instr is set:
  - Latch addr, funct3, byte_off, we, be and wdata.
  - Check the access. Misaligned means H/HU with byte_off=3, or W with byte_off≠0. Illegal means an undefined funct3 (011/110/111 for loads, ≥011 for stores).
  - Misaligned or illegal: go to DONE with err=1 and issue no memory request.
  - Otherwise: go to REQ and set the timeout counter to 0.
- IDLE with mem_en=1 and both or neither of is_l_instr/is_s_instr set: go to DONE with err=1.
- Lanes:
  - B: be = 4'b0001<<off, wdata = {4{d[7:0]}}.
  - H: be = 4'b0011<<off, wdata = {2{d[15:0]}}.
  - W: be = 4'b1111, wdata = d.
  - Loads drive the same be pattern.
- REQ: dmem_req=1 and all dmem_* outputs stay stable.
  - dmem_ready=1: for a load, compute (rdata >> 8*off), then extend by funct3 into load_data. Then go to DONE with err=0.
  - Else, when the counter reaches TIMEOUT−1: go to DONE with err=1; load_data is unchanged.
  - Else: increment the counter.
- DONE: done=1, err valid, rd_wr_en=1 if load and !err. Go to IDLE unconditionally.
- mem_en outside IDLE is ignored; no queuing.
- Reset mid-transaction: immediately return to IDLE and drop dmem_req. The memory side must tolerate an abandoned request.

## Timing
- All outputs are registered. Reset values:
  - state=IDLE; busy, done, err, rd_wr_en, dmem_req, dmem_we = 0.
  - dmem_addr, dmem_be, dmem_wdata, load_data = 0.
- Start sampled at edge 0: dmem_req is high in cycle 1. dmem_ready in cycle k (k≥1) gives done in cycle k+1.
- Minimum latency is 2 cycles from start to done.
- Error paths:
  - Misaligned or illegal: done+err in cycle 1.
  - Timeout: dmem_req is high for exactly TIMEOUT cycles, done+err follows in the next cycle.
- dmem_ready in the final permitted REQ cycle counts as success; ready wins over timeout.
- The earliest next start is accepted on the edge that ends DONE's cycle (state=IDLE at that edge).
- dmem_ready while not in REQ is ignored.

## Test plan
- LW: addr=0x010, off=0, rdata=0xDEADBEEF, ready in 1st REQ cycle → dmem_be=1111, done at cycle 2, load_data=0xDEADBEEF, rd_wr_en=1, err=0.
- LB/LBU: off=2, rdata=0x12F45678 → LB load_data=0xFFFFFFF4; LBU=0x000000F4. LH off=2, rdata=0x8001xxxx → 0xFFFF8001.
- SB: off=3, data=0x000000AB → dmem_we=1, dmem_be=1000, dmem_wdata=0xABABABAB, done with rd_wr_en=0. SH off=2, data=0x1234 → be=1100, wdata=0x12341234.
- Misaligned and illegal: LW off=1 → done+err at cycle 1, dmem_req never asserted. Same for SH off=3 and for is_l_instr=is_s_instr=1.
- Timeout (TIMEOUT=4): ready held 0 → dmem_req high 4 cycles, done+err next, load_data unchanged. Repeat with ready in 4th cycle → success.
- Assert rst during REQ → dmem_req and busy drop asynchronously. Follow with a clean LW that completes normally; a mem_en pulse during busy has no effect.
